// File: rtl/ram_bist_initiator.sv
// ram_bist_initiator: four-phase march test (write P, read P, write ~P,
// read ~P descending) driving a single-port RAM with one-cycle read latency.
// Reports pass/fail with the first failing address and the data read there.
// Optional build macro BIST_ERR_COUNT_EN: never abort, count all mismatches
// in a saturating err_count output instead.
module ram_bist_initiator #(
  parameter int                WIDTH   = 8,
  parameter int                DEPTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = WIDTH'(8'hA5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [DEPTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data,
`ifdef BIST_ERR_COUNT_EN
  output logic [DEPTH+1:0] err_count,
`endif
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [DEPTH-1:0] LAST  = '1;
  localparam logic [WIDTH-1:0] PAT_N = ~PATTERN;

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic             busy_n, done_n, pass_n, wr_n, rd_n;
  logic [DEPTH-1:0] addr_n, fail_addr_n;
  logic [WIDTH-1:0] wdata_n, fail_data_n;
  logic             fail_seen, fail_seen_n;
  logic             start_ok, mismatch, first, abort, last_addr;

  // Compare pipeline: read tag issued in cycle n, checked in cycle n+1
  logic             vld_p1;
  logic [DEPTH-1:0] addr_p1;
  logic [WIDTH-1:0] exp_p1;

`ifdef BIST_ERR_COUNT_EN
  logic [DEPTH+1:0] err_count_n;

  function automatic logic [DEPTH+1:0] sat_inc(input logic [DEPTH+1:0] v);
    return (v == '1) ? v : v + (DEPTH+2)'(1);
  endfunction
`endif

  // Next-state, next-output and result-field logic
  always_comb begin
    start_ok  = start && (state == IDLE || state == DONE);
    mismatch  = vld_p1 && (mem_rdata != exp_p1);
    first     = mismatch && !fail_seen;
`ifdef BIST_ERR_COUNT_EN
    abort     = 1'b0;
`else
    abort     = mismatch;
`endif
    last_addr = (state == RD1) ? (mem_addr == '0) : (mem_addr == LAST);

    state_n = state;
    case (state)
      IDLE, DONE: if (start_ok)  state_n = WR0;
      WR0:        if (last_addr) state_n = RD0;
      RD0:        if (last_addr) state_n = WR1;
      WR1:        if (last_addr) state_n = RD1;
      RD1:        if (last_addr) state_n = DRAIN;
      DRAIN:                     state_n = DONE;
      default:                   state_n = IDLE;
    endcase
    if (abort) state_n = DONE;

    addr_n = '0;
    case (state_n)
      WR0, RD0, WR1: addr_n = (state_n == state) ? mem_addr + DEPTH'(1) : '0;
      RD1:           addr_n = (state_n == state) ? mem_addr - DEPTH'(1) : LAST;
      default:       addr_n = '0;
    endcase

    wr_n    = (state_n == WR0) || (state_n == WR1);
    rd_n    = (state_n == RD0) || (state_n == RD1);
    wdata_n = (state_n == WR0) ? PATTERN : (state_n == WR1) ? PAT_N : '0;
    busy_n  = !(state_n == IDLE || state_n == DONE);
    done_n  = (state_n == DONE);

    fail_seen_n = start_ok ? 1'b0 : (fail_seen | mismatch);
    fail_addr_n = start_ok ? '0 : (first ? addr_p1   : fail_addr);
    fail_data_n = start_ok ? '0 : (first ? mem_rdata : fail_data);
    pass_n      = done_n && !fail_seen_n;
`ifdef BIST_ERR_COUNT_EN
    err_count_n = start_ok ? '0 : (mismatch ? sat_inc(err_count) : err_count);
`endif
  end

  // State and all registered outputs; reset clears them asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      fail_seen <= 1'b0;
      vld_p1    <= 1'b0;
`ifdef BIST_ERR_COUNT_EN
      err_count <= '0;
`endif
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      fail_addr <= fail_addr_n;
      fail_data <= fail_data_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_wr_en <= wr_n;
      mem_rd_en <= rd_n;
      fail_seen <= fail_seen_n;
      vld_p1    <= mem_rd_en && !abort;
`ifdef BIST_ERR_COUNT_EN
      err_count <= err_count_n;
`endif
    end
  end

  // Address and expected data of the read issued this cycle, used next cycle
  always_ff @(posedge clk) begin
    addr_p1 <= mem_addr;
    exp_p1  <= (state == RD1) ? PAT_N : PATTERN;
  end

endmodule

// File: tb/tb_ram_bist_initiator.sv
// Directed bench for ram_bist_initiator with a behavioural RAM that can
// force bits on read per address (and-mask / or-mask).
module tb_ram_bist_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;
`ifdef BIST_ERR_COUNT_EN
  logic [5:0] err_count;
`endif
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en, mem_rd_en;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] mem  [16];
  logic [7:0] andm [16];
  logic [7:0] orm  [16];

  int checks = 0;
  int errors = 0;

  ram_bist_initiator #(.WIDTH(8), .DEPTH(4), .PATTERN(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
`ifdef BIST_ERR_COUNT_EN
    .err_count (err_count),
`endif
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, faults applied on the read path
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= (mem[mem_addr] & andm[mem_addr]) | orm[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      andm[i] = 8'hFF;
      orm[i]  = 8'h00;
    end
  endtask

  // Pulse start, then check the bus every cycle up to cycle 'stop', where
  // the block is expected to sit in DONE. 'mid' re-pulses start in that cycle.
  task automatic run_test(input int stop, input int mid);
    int         ph, ix;
    logic [7:0] ev;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c <= stop; c++) begin
      @(negedge clk);
      start = (c == mid);
      if (c == 0)
        chk("cleared_on_start", {done, pass, fail_addr, fail_data}, 14'h0);
      if (c < stop) begin
        ph = c / 16;
        ix = c % 16;
        if (c >= 64) ev = 8'b1000_0000;
        else ev = {1'b1, 1'b0, (ph % 2 == 0), (ph % 2 == 1),
                   4'((ph == 3) ? 15 - ix : ix)};
        chk($sformatf("bus_c%0d", c), {busy, done, mem_wr_en, mem_rd_en, mem_addr}, ev);
        if (ev[5])
          chk($sformatf("wdata_c%0d", c), mem_wdata, (ph == 0) ? 8'hA5 : 8'h5A);
      end else begin
        chk("done_state", {busy, done, mem_wr_en, mem_rd_en, mem_addr}, 8'b0100_0000);
      end
    end
  endtask

  initial begin
    clear_faults();
    // Reset state
    #12;
    chk("rst_outputs", {busy, done, pass, mem_wr_en, mem_rd_en, mem_addr,
                        mem_wdata, fail_addr, fail_data}, 33'h0);
`ifdef BIST_ERR_COUNT_EN
    chk("rst_err_count", err_count, 6'd0);
`endif
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {busy, done, mem_wr_en, mem_rd_en}, 4'h0);

    // Good run with a start pulse in WR1 (cycle 40) that must be ignored;
    // the RD0 addr 15 compare lands in the WR1 addr 0 cycle without a fail
    run_test(65, 40);
    chk("good1_result", {pass, fail_addr, fail_data}, 13'h1000);
    @(negedge clk);
    chk("good1_hold", {busy, done, pass}, 3'b011);

`ifndef BIST_ERR_COUNT_EN
    // Addr 7 bit0 stuck-at-1: RD1 reads 5B at cycle 56, abort at cycle 58
    orm[7] = 8'h01;
    run_test(58, -1);
    chk("stuck7_result", {pass, fail_addr, fail_data}, {1'b0, 4'd7, 8'h5B});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stuck7_quiet%0d", k), {busy, done, mem_wr_en, mem_rd_en}, 4'b0100);
    end
    clear_faults();

    // Restart from DONE after a fail: fields clear, full good rerun
    run_test(65, -1);
    chk("rerun_result", {pass, fail_addr, fail_data}, 13'h1000);

    // Real fault on RD0 addr 15: compared in WR1 addr 0 cycle, DONE at 33
    orm[15] = 8'h02;
    run_test(33, -1);
    chk("rd0_last_result", {pass, fail_addr, fail_data}, {1'b0, 4'd15, 8'hA7});
    clear_faults();
`endif

    // Reset mid-RD0 at address 5 (cycle 21), away from any clock edge
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (21) @(negedge clk);
    chk("pre_rst_rd0_a5", {busy, mem_rd_en, mem_addr}, {1'b1, 1'b1, 4'd5});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy, done, mem_wr_en, mem_rd_en, mem_addr}, 8'h0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", k), {busy, done, mem_wr_en, mem_rd_en}, 4'h0);
    end

`ifdef BIST_ERR_COUNT_EN
    // Addr 3 bit7 stuck-at-0 (A5 -> 25), addr 9 reads 0: three mismatches
    andm[3] = 8'h7F;
    andm[9] = 8'h00;
    run_test(65, -1);
    chk("errcnt_fields", {pass, fail_addr, fail_data}, {1'b0, 4'd3, 8'h25});
    chk("errcnt_value", err_count, 6'd3);
    clear_faults();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
